// File: rtl/serial_io_pkg.sv
// Shared types and frame-geometry helpers for the serial frame bridge.
package serial_io_pkg;

    localparam int IDLE_DEFAULT = 0;

    typedef enum logic [1:0] {
        WIN_IN  = 2'd0,
        WIN_RUN = 2'd1,
        WIN_OUT = 2'd2
    } window_e;

    function automatic int frame_len(input int in_w, input int out_w);
        return in_w + 1 + out_w;
    endfunction

    function automatic int phase_width(input int p);
        int w;
        w = 1;
        while ((1 << w) < p) w++;
        return w;
    endfunction

endpackage

// File: rtl/serial_frame_bridge_if.sv
// Pad-side and core-side signal bundle of the serial frame bridge.
interface serial_frame_bridge_if
    import serial_io_pkg::*;
#(
    parameter int IO_W      = 12,
    parameter int IN_WORDS  = 4,
    parameter int OUT_WORDS = 2
);
    localparam int PH_W = phase_width(frame_len(IN_WORDS, OUT_WORDS));

    logic [IO_W-1:0]           in_bits;
    logic                      frame_sync;
    logic                      loopback;
    logic [IO_W-1:0]           out_bits;
    logic                      out_valid;
    logic                      core_clk;
    logic [IN_WORDS*IO_W-1:0]  core_in;
    logic [OUT_WORDS*IO_W-1:0] core_out;
    logic [PH_W-1:0]           phase;
    logic                      desync;

    modport slave (
        input  in_bits, frame_sync, loopback, core_out,
        output out_bits, out_valid, core_clk, core_in, phase, desync
    );

    modport master (
        output in_bits, frame_sync, loopback, core_out,
        input  out_bits, out_valid, core_clk, core_in, phase, desync
    );

endinterface

// File: rtl/serial_phase_gen.sv
// Frame phase sequencer: phase counter, resync/abort handling, sticky desync
// flag and the registered divided core clock.
module serial_phase_gen
    import serial_io_pkg::*;
#(
    parameter int IN_WORDS  = 4,
    parameter int OUT_WORDS = 2,
    localparam int P    = frame_len(IN_WORDS, OUT_WORDS),
    localparam int PH_W = phase_width(P)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            frame_sync,
    output logic [PH_W-1:0] phase,
    output window_e         window,
    output logic            is_last,
    output logic            abort,
    output logic            core_clk,
    output logic            desync
);

    logic [PH_W-1:0] next_phase;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            core_clk <= 1'b0;
            desync   <= 1'b0;
        end else begin
            phase    <= next_phase;
            core_clk <= (next_phase >= PH_W'(IN_WORDS));
            desync   <= desync | abort;
        end
    end

    // next-state: a sync on the last phase is just the ordinary wrap
    always_comb begin
        is_last = (phase == PH_W'(P - 1));
        abort   = frame_sync && !is_last;
        if (frame_sync || is_last) begin
            next_phase = '0;
        end else begin
            next_phase = phase + PH_W'(1);
        end
    end

    // output: classify the current phase
    always_comb begin
        window = WIN_OUT;
        if (phase < PH_W'(IN_WORDS)) begin
            window = WIN_IN;
        end else if (phase == PH_W'(IN_WORDS)) begin
            window = WIN_RUN;
        end
    end

endmodule

// File: rtl/serial_frame_bridge.sv
// Pin-limited serial bridge: captures IN_WORDS pad words into a wide core
// input, runs the core for one phase, then serialises OUT_WORDS results.
module serial_frame_bridge
    import serial_io_pkg::*;
#(
    parameter int IO_W      = 12,
    parameter int IN_WORDS  = 4,
    parameter int OUT_WORDS = 2,
    parameter int IDLE_VAL  = IDLE_DEFAULT
) (
    input logic                  clk,
    input logic                  reset_n,
    serial_frame_bridge_if.slave bus
);

    localparam int P    = frame_len(IN_WORDS, OUT_WORDS);
    localparam int PH_W = phase_width(P);
    localparam logic [IO_W-1:0] IDLE_W = IO_W'(IDLE_VAL);

    logic [PH_W-1:0] phase;
    window_e         window;
    logic            is_last;
    logic            abort;
    logic            core_clk;
    logic            desync;

    logic [IO_W-1:0] core_in_r  [IN_WORDS];
    logic [IO_W-1:0] snapshot_r [OUT_WORDS];
    logic [IO_W-1:0] snap_d     [OUT_WORDS];
    logic            load_snap;
    logic [IO_W-1:0] out_d;
    logic            valid_d;
    logic [IO_W-1:0] out_bits_r;
    logic            out_valid_r;

    serial_phase_gen #(
        .IN_WORDS  (IN_WORDS),
        .OUT_WORDS (OUT_WORDS)
    ) u_phase_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_sync (bus.frame_sync),
        .phase      (phase),
        .window     (window),
        .is_last    (is_last),
        .abort      (abort),
        .core_clk   (core_clk),
        .desync     (desync)
    );

    // input window: one pad word per phase into the wide core input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < IN_WORDS; k++) core_in_r[k] <= '0;
        end else begin
            for (int k = 0; k < IN_WORDS; k++) begin
                if (phase == PH_W'(k)) core_in_r[k] <= bus.in_bits;
            end
        end
    end

    // run phase: no capture happens here, so core_in_r is already the full frame
    always_comb begin
        for (int j = 0; j < OUT_WORDS; j++) begin
            snap_d[j] = bus.loopback ? core_in_r[j % IN_WORDS]
                                     : bus.core_out[j*IO_W +: IO_W];
        end
    end

    assign load_snap = (window == WIN_RUN) && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < OUT_WORDS; j++) snapshot_r[j] <= '0;
        end else if (load_snap) begin
            for (int j = 0; j < OUT_WORDS; j++) snapshot_r[j] <= snap_d[j];
        end
    end

    // word 0 leaves on the same edge the snapshot loads, hence the bypass
    always_comb begin
        out_d   = IDLE_W;
        valid_d = 1'b0;
        if (!abort && !is_last) begin
            if (window == WIN_RUN) begin
                out_d   = snap_d[0];
                valid_d = 1'b1;
            end else begin
                for (int j = 1; j < OUT_WORDS; j++) begin
                    if (phase == PH_W'(IN_WORDS + j)) begin
                        out_d   = snapshot_r[j];
                        valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_bits_r  <= IDLE_W;
            out_valid_r <= 1'b0;
        end else begin
            out_bits_r  <= out_d;
            out_valid_r <= valid_d;
        end
    end

    for (genvar k = 0; k < IN_WORDS; k++) begin : g_core_in
        assign bus.core_in[k*IO_W +: IO_W] = core_in_r[k];
    end

    assign bus.out_bits  = out_bits_r;
    assign bus.out_valid = out_valid_r;
    assign bus.core_clk  = core_clk;
    assign bus.phase     = phase;
    assign bus.desync    = desync;

endmodule

// File: tb/tb_serial_frame_bridge.sv
// Bench for serial_frame_bridge: three configurations checked frame by frame
// against a frame-level model of capture, core clock and output windows.
module tb_serial_frame_bridge;

    logic        clk;
    logic        reset_n;
    logic [11:0] drv_in;
    logic        drv_sync;
    logic        drv_lb;
    logic [71:0] drv_core_out;
    int          sel;

    int vec;
    int miss;
    bit exp_desync;

    logic [4:0]  obs_phase;
    logic [11:0] obs_out;
    logic        obs_valid;
    logic        obs_clk;
    logic [47:0] obs_core_in;
    logic        obs_desync;

    serial_frame_bridge_if #(.IO_W(12), .IN_WORDS(4), .OUT_WORDS(2)) a_if();
    serial_frame_bridge_if #(.IO_W(12), .IN_WORDS(4), .OUT_WORDS(6)) b_if();
    serial_frame_bridge_if #(.IO_W(8),  .IN_WORDS(1), .OUT_WORDS(3)) c_if();

    serial_frame_bridge #(.IO_W(12), .IN_WORDS(4), .OUT_WORDS(2), .IDLE_VAL(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
    serial_frame_bridge #(.IO_W(12), .IN_WORDS(4), .OUT_WORDS(6), .IDLE_VAL(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if.slave));
    serial_frame_bridge #(.IO_W(8), .IN_WORDS(1), .OUT_WORDS(3), .IDLE_VAL(8'h5A)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(c_if.slave));

    assign a_if.in_bits    = drv_in;
    assign b_if.in_bits    = drv_in;
    assign c_if.in_bits    = drv_in[7:0];
    assign a_if.frame_sync = drv_sync && (sel == 0);
    assign b_if.frame_sync = drv_sync && (sel == 1);
    assign c_if.frame_sync = drv_sync && (sel == 2);
    assign a_if.loopback   = drv_lb;
    assign b_if.loopback   = drv_lb;
    assign c_if.loopback   = drv_lb;
    assign a_if.core_out   = drv_core_out[23:0];
    assign b_if.core_out   = drv_core_out;
    assign c_if.core_out   = drv_core_out[23:0];

    always_comb begin
        obs_phase   = '0;
        obs_out     = '0;
        obs_valid   = 1'b0;
        obs_clk     = 1'b0;
        obs_core_in = '0;
        obs_desync  = 1'b0;
        case (sel)
            0: begin
                obs_phase = 5'(a_if.phase); obs_out = a_if.out_bits; obs_valid = a_if.out_valid;
                obs_clk = a_if.core_clk; obs_core_in = a_if.core_in; obs_desync = a_if.desync;
            end
            1: begin
                obs_phase = 5'(b_if.phase); obs_out = b_if.out_bits; obs_valid = b_if.out_valid;
                obs_clk = b_if.core_clk; obs_core_in = b_if.core_in; obs_desync = b_if.desync;
            end
            default: begin
                obs_phase = 5'(c_if.phase); obs_out = {4'h0, c_if.out_bits}; obs_valid = c_if.out_valid;
                obs_clk = c_if.core_clk; obs_core_in = {40'h0, c_if.core_in}; obs_desync = c_if.desync;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int in_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction
    function automatic int out_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 6 : 3;
    endfunction
    function automatic int w_of(input int s);
        return (s == 2) ? 8 : 12;
    endfunction
    function automatic logic [11:0] idle_of(input int s);
        return (s == 2) ? 12'h05A : 12'h000;
    endfunction

    task automatic do_reset();
        drv_sync = 1'b0;
        drv_lb   = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        exp_desync = 1'b0;
    endtask

    // Runs one frame from phase 0; a sync at sync_at truncates it there.
    task automatic run_frame(input int s, input logic [11:0] w[4], input bit lb,
                             input logic [71:0] co, input int sync_at, input int stop_at);
        int nin, nout, p, wd, last;
        logic [11:0] mask, idle, exp_out;
        logic [47:0] exp_ci;
        bit exp_v, exp_c;
        nin  = in_of(s);
        nout = out_of(s);
        wd   = w_of(s);
        idle = idle_of(s);
        p    = nin + 1 + nout;
        last = (sync_at >= 0) ? sync_at : p - 1;
        mask = (wd == 12) ? 12'hFFF : 12'h0FF;
        exp_ci = '0;
        for (int k = 0; k < nin; k++) exp_ci = exp_ci | (48'(w[k] & mask) << (k * wd));
        for (int t = 0; t <= last; t++) begin
            exp_c = (t >= nin);
            exp_v = (t >= nin + 1);
            if (!exp_v) exp_out = idle;
            else if (lb) exp_out = w[(t - nin - 1) % nin] & mask;
            else exp_out = 12'(co >> ((t - nin - 1) * wd)) & mask;
            vec++;
            if (obs_phase !== 5'(t)) begin
                miss++; $display("FAIL phase dut=%0d t=%0d got=%0d exp=%0d", s, t, obs_phase, t);
            end
            vec++;
            if (obs_clk !== exp_c) begin
                miss++; $display("FAIL core_clk dut=%0d t=%0d got=%b exp=%b", s, t, obs_clk, exp_c);
            end
            vec++;
            if (obs_valid !== exp_v) begin
                miss++; $display("FAIL out_valid dut=%0d t=%0d got=%b exp=%b", s, t, obs_valid, exp_v);
            end
            vec++;
            if (obs_out !== exp_out) begin
                miss++; $display("FAIL out_bits dut=%0d t=%0d got=%h exp=%h", s, t, obs_out, exp_out);
            end
            vec++;
            if (obs_desync !== exp_desync) begin
                miss++; $display("FAIL desync dut=%0d t=%0d got=%b exp=%b", s, t, obs_desync, exp_desync);
            end
            if (t == nin) begin
                vec++;
                if (obs_core_in !== exp_ci) begin
                    miss++; $display("FAIL core_in dut=%0d got=%h exp=%h", s, obs_core_in, exp_ci);
                end
            end
            if (t == stop_at) return;
            drv_in       = (t < nin) ? w[t] : 12'($urandom);
            drv_sync     = (t == sync_at);
            drv_lb       = (t <= nin) ? lb : ~lb;
            drv_core_out = (t <= nin) ? co : 72'({$urandom, $urandom, $urandom});
            @(negedge clk);
        end
        drv_sync = 1'b0;
        if (sync_at >= 0 && sync_at != p - 1) exp_desync = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            vec++;
            if (obs_phase !== 5'd0) begin miss++; $display("FAIL rst_phase dut=%0d got=%0d exp=0", s, obs_phase); end
            vec++;
            if (obs_out !== idle_of(s)) begin miss++; $display("FAIL rst_out dut=%0d got=%h exp=%h", s, obs_out, idle_of(s)); end
            vec++;
            if (obs_valid !== 1'b0 || obs_clk !== 1'b0 || obs_desync !== 1'b0) begin
                miss++; $display("FAIL rst_ctl dut=%0d got=%b%b%b exp=000", s, obs_valid, obs_clk, obs_desync);
            end
            vec++;
            if (obs_core_in !== 48'h0) begin miss++; $display("FAIL rst_core_in dut=%0d got=%h exp=0", s, obs_core_in); end
        end
    endtask

    task automatic test_basic();
        logic [11:0] w[4];
        sel = 0;
        do_reset();
        w = '{12'hA01, 12'h0B2, 12'hC03, 12'h0D4};
        run_frame(0, w, 1'b0, 72'({w[1], w[0]}), -1, -1);
        w = '{12'h123, 12'h456, 12'h789, 12'hABC};
        run_frame(0, w, 1'b0, 72'({12'hFED, 12'h321}), -1, -1);
    endtask

    task automatic test_loopback();
        logic [11:0] w[4];
        sel = 1;
        do_reset();
        w = '{12'hA01, 12'h0B2, 12'hC03, 12'h0D4};
        run_frame(1, w, 1'b1, 72'({$urandom, $urandom, $urandom}), -1, -1);
        run_frame(1, w, 1'b0, 72'({$urandom, $urandom, $urandom}), -1, -1);
    endtask

    task automatic test_abort();
        logic [11:0] w[4];
        sel = 0;
        do_reset();
        w = '{12'hA01, 12'h0B2, 12'hC03, 12'h0D4};
        run_frame(0, w, 1'b0, 72'({w[1], w[0]}), 2, -1);
        run_frame(0, w, 1'b0, 72'({w[1], w[0]}), -1, -1);
        run_frame(0, w, 1'b1, 72'h0, 5, -1);
        run_frame(0, w, 1'b0, 72'h0, 4, -1);
        run_frame(0, w, 1'b1, 72'h0, -1, -1);
    endtask

    task automatic test_sync_wrap();
        logic [11:0] w[4];
        sel = 0;
        do_reset();
        w = '{12'h111, 12'h222, 12'h333, 12'h444};
        run_frame(0, w, 1'b0, 72'({12'h555, 12'h666}), 6, -1);
        run_frame(0, w, 1'b1, 72'h0, -1, -1);
    endtask

    task automatic test_async_reset();
        logic [11:0] w[4];
        sel = 0;
        do_reset();
        w = '{12'hA01, 12'h0B2, 12'hC03, 12'h0D4};
        run_frame(0, w, 1'b0, 72'({w[1], w[0]}), -1, 5);
        #2 reset_n = 1'b0;
        #1;
        vec++;
        if (obs_phase !== 5'd0 || obs_valid !== 1'b0 || obs_clk !== 1'b0) begin
            miss++; $display("FAIL async_rst_ctl got=%0d/%b/%b exp=0/0/0", obs_phase, obs_valid, obs_clk);
        end
        vec++;
        if (obs_out !== 12'h000 || obs_core_in !== 48'h0) begin
            miss++; $display("FAIL async_rst_data got=%h/%h exp=0/0", obs_out, obs_core_in);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        exp_desync = 1'b0;
        w = '{12'h0F1, 12'h0E2, 12'h0D3, 12'h0C4};
        run_frame(0, w, 1'b0, 72'({12'h9AB, 12'h8CD}), -1, -1);
    endtask

    task automatic test_small();
        logic [11:0] w[4];
        sel = 2;
        do_reset();
        w = '{12'h0C3, 12'h000, 12'h000, 12'h000};
        run_frame(2, w, 1'b0, 72'h00_0000_A5B6C7, -1, -1);
        run_frame(2, w, 1'b1, 72'h0, -1, -1);
        run_frame(2, w, 1'b0, 72'h00_0000_112233, 1, -1);
        run_frame(2, w, 1'b0, 72'h00_0000_445566, -1, -1);
    endtask

    task automatic test_back_to_back_random();
        logic [11:0] w[4];
        int s, p, sa;
        for (int it = 0; it < 12; it++) begin
            s = int'($urandom_range(0, 2));
            sel = s;
            do_reset();
            p = in_of(s) + 1 + out_of(s);
            for (int f = 0; f < 4; f++) begin
                for (int k = 0; k < 4; k++) w[k] = 12'($urandom);
                sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p - 1)) : -1;
                run_frame(s, w, 1'($urandom), 72'({$urandom, $urandom, $urandom}), sa, -1);
            end
        end
    endtask

    initial begin
        vec          = 0;
        miss         = 0;
        sel          = 0;
        exp_desync   = 1'b0;
        reset_n      = 1'b0;
        drv_in       = '0;
        drv_sync     = 1'b0;
        drv_lb       = 1'b0;
        drv_core_out = '0;
        test_reset();
        test_basic();
        test_loopback();
        test_abort();
        test_sync_wrap();
        test_async_reset();
        test_small();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
